// File: rtl/tc3_mul_seq.sv
// tc3_mul_seq: sequenced Toom-Cook-3 multiplier, 3 limbs x 3 limbs, unsigned.
// One shared signed multiplier feeds a four-step Bodrato interpolation.
module tc3_mul_seq #(
    parameter int LIMB_W  = 64,
    parameter int MUL_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3*LIMB_W-1:0]   a,
    input  logic [3*LIMB_W-1:0]   b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [6*LIMB_W-1:0]   result,
    output logic                  busy
);

    localparam int W  = LIMB_W;
    localparam int EW = W + 4;
    localparam int PW = 2 * W + 8;
    localparam int RW = 6 * W;
    localparam logic signed [PW-1:0] INV3 = {{(PW/2-1){2'b10}}, 2'b11};

    typedef enum logic [3:0] {
        S_IDLE, S_EVAL, S_MUL, S_DRAIN,
        S_INT0, S_INT1, S_INT2, S_PACK, S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [3*W-1:0]        a_q, b_q;
    logic signed [EW-1:0]  pa_q [5];
    logic signed [EW-1:0]  pb_q [5];
    logic signed [PW-1:0]  v_q  [5];
    logic signed [PW-1:0]  r1_q, r2_q, r3_q;
    logic signed [PW-1:0]  r1_d, r2_d, r3_d;
    logic [RW-1:0]         res_q, res_d;
    logic [2:0]            k_q;
    logic [7:0]            dcnt_q;

    logic signed [PW-1:0]  mp, wp;
    logic                  mv, wv;
    logic [2:0]            mk, wk;

    // Evaluation point k of {x2,x1,x0}: 0, 1, -1, -2, inf.
    function automatic logic signed [EW-1:0] evp(
        input logic [3*W-1:0] x,
        input int             k
    );
        logic signed [EW-1:0] x0, x1, x2;
        x0 = EW'(x[W-1:0]);
        x1 = EW'(x[2*W-1:W]);
        x2 = EW'(x[3*W-1:2*W]);
        case (k)
            0:       return x0;
            1:       return x0 + x1 + x2;
            2:       return x0 - x1 + x2;
            3:       return x0 - (x1 <<< 1) + (x2 <<< 2);
            default: return x2;
        endcase
    endfunction

    function automatic logic [RW-1:0] sx(input logic signed [PW-1:0] x);
        return {{(RW-PW){x[PW-1]}}, x};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_EVAL;
            S_EVAL:  state_d = S_MUL;
            S_MUL:   if (k_q == 3'd4)
                         state_d = (MUL_LAT > 1) ? S_DRAIN : S_INT0;
            S_DRAIN: if (dcnt_q == 8'(MUL_LAT - 2)) state_d = S_INT0;
            S_INT0:  state_d = S_INT1;
            S_INT1:  state_d = S_INT2;
            S_INT2:  state_d = S_PACK;
            S_PACK:  state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        if (state_q == S_IDLE) begin
            in_ready = 1'b1;
            busy     = 1'b0;
        end
        if (state_q == S_DONE) out_valid = 1'b1;
    end

    assign result = res_q;

    assign mp = PW'(pa_q[k_q]) * PW'(pb_q[k_q]);
    assign mv = (state_q == S_MUL);
    assign mk = k_q;

    // The final pipeline stage writes straight into the product registers.
    generate
        if (MUL_LAT == 1) begin : g_nopipe
            assign wp = mp;
            assign wv = mv;
            assign wk = mk;
        end else begin : g_pipe
            logic signed [PW-1:0] pp_q [MUL_LAT-1];
            logic                 pv_q [MUL_LAT-1];
            logic [2:0]           pk_q [MUL_LAT-1];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < MUL_LAT - 1; i++) begin
                        pp_q[i] <= '0;
                        pv_q[i] <= 1'b0;
                        pk_q[i] <= '0;
                    end
                end else begin
                    pp_q[0] <= mp;
                    pv_q[0] <= mv;
                    pk_q[0] <= mk;
                    for (int i = 1; i < MUL_LAT - 1; i++) begin
                        pp_q[i] <= pp_q[i-1];
                        pv_q[i] <= pv_q[i-1];
                        pk_q[i] <= pk_q[i-1];
                    end
                end
            end
            assign wp = pp_q[MUL_LAT-2];
            assign wv = pv_q[MUL_LAT-2];
            assign wk = pk_q[MUL_LAT-2];
        end
    endgenerate

    always_comb begin
        r1_d  = r1_q;
        r2_d  = r2_q;
        r3_d  = r3_q;
        res_d = res_q;
        case (state_q)
            S_INT0: begin
                r3_d = (v_q[3] - v_q[1]) * INV3;
                r1_d = (v_q[1] - v_q[2]) >>> 1;
                r2_d = v_q[2] - v_q[0];
            end
            S_INT1: begin
                r3_d = ((r2_q - r3_q) >>> 1) + (v_q[4] <<< 1);
                r2_d = r2_q + r1_q - v_q[4];
            end
            S_INT2: r1_d = r1_q - r3_q;
            S_PACK: res_d = sx(v_q[0])
                          + (sx(r1_q) << W)
                          + (sx(r2_q) << (2 * W))
                          + (sx(r3_q) << (3 * W))
                          + (sx(v_q[4]) << (4 * W));
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            k_q    <= '0;
            dcnt_q <= '0;
            r1_q   <= '0;
            r2_q   <= '0;
            r3_q   <= '0;
            res_q  <= '0;
            for (int i = 0; i < 5; i++) begin
                pa_q[i] <= '0;
                pb_q[i] <= '0;
                v_q[i]  <= '0;
            end
        end else begin
            r1_q  <= r1_d;
            r2_q  <= r2_d;
            r3_q  <= r3_d;
            res_q <= res_d;
            if (wv) v_q[wk] <= wp;
            case (state_q)
                S_IDLE: if (in_valid) begin
                    a_q <= a;
                    b_q <= b;
                end
                S_EVAL: begin
                    for (int i = 0; i < 5; i++) begin
                        pa_q[i] <= evp(a_q, i);
                        pb_q[i] <= evp(b_q, i);
                    end
                    k_q <= 3'd0;
                end
                S_MUL: begin
                    k_q    <= k_q + 3'd1;
                    dcnt_q <= 8'd0;
                end
                S_DRAIN: dcnt_q <= dcnt_q + 8'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tc3_mul_seq.sv
// tb_tc3_mul_seq: directed checks of tc3_mul_seq products, latency,
// backpressure and mid-operation reset.
module tb_tc3_mul_seq;

    localparam int ML = 1;
    localparam int LAT = 9 + ML;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [191:0] a = '0;
    logic [191:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [383:0] result;
    logic         busy;

    int checks = 0;
    int failures = 0;

    tc3_mul_seq #(.LIMB_W(64), .MUL_LAT(ML)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [383:0] got,
                       input logic [383:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic start(input logic [191:0] av, input logic [191:0] bv);
        @(negedge clk);
        a = av;
        b = bv;
        in_valid = 1'b1;
        chk("in_ready_idle", 384'(in_ready), 384'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("busy_run", 384'(busy), 384'd1);
    endtask

    task automatic wait_done(input string tag, input logic [383:0] exp);
        int cyc;
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        chk({tag, "_lat"}, 384'(cyc), 384'(LAT));
        chk({tag, "_res"}, result, exp);
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("ovalid_after", 384'(out_valid), 384'd0);
        chk("iready_after", 384'(in_ready), 384'd1);
    endtask

    logic [383:0] ones_exp;
    logic [383:0] held;
    int seen;

    initial begin
        ones_exp = {384{1'b1}} - (384'd1 << 193) + 384'd2;

        #3;
        chk("rst_in_ready", 384'(in_ready), 384'd1);
        chk("rst_out_valid", 384'(out_valid), 384'd0);
        chk("rst_busy", 384'(busy), 384'd0);
        chk("rst_result", result, 384'd0);
        @(negedge clk);
        rst_n = 1'b1;

        start('0, '0);
        wait_done("zero", 384'd0);
        take();

        start({192{1'b1}}, {192{1'b1}});
        wait_done("ones", ones_exp);
        take();

        start(192'd1 << 128, 192'd1 << 128);
        wait_done("hi_limb", 384'd1 << 256);
        take();

        start(192'd1, 192'd1 << 191);
        wait_done("lo_x_top", 384'd1 << 191);
        take();

        out_ready = 1'b1;
        start({64'd2, 64'd3, 64'd4}, {64'd5, 64'd6, 64'd7});
        wait_done("limbs",
                  {64'd0, 64'd10, 64'd27, 64'd52, 64'd45, 64'd28});
        take();

        start({192{1'b1}}, 192'd1);
        wait_done("ones_x1", {192'd0, {192{1'b1}}});
        take();

        start(192'd1 << 64, 192'd1 << 64);
        wait_done("mid_limb", 384'd1 << 128);
        take();

        start(192'd5, 192'd7);
        wait_done("bp", 384'd35);
        held = result;
        a = 192'd9;
        b = 192'd11;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_result", result, held);
            chk("bp_ovalid", 384'(out_valid), 384'd1);
            chk("bp_iready", 384'(in_ready), 384'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk("bp_iready_back", 384'(in_ready), 384'd1);
        start(192'd9, 192'd11);
        wait_done("bp_next", 384'd99);
        take();

        start(192'd7, 192'd9);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_result", result, 384'd0);
        chk("mid_rst_busy", 384'(busy), 384'd0);
        chk("mid_rst_iready", 384'(in_ready), 384'd1);
        chk("mid_rst_ovalid", 384'(out_valid), 384'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("no_spurious", 384'(seen), 384'd0);
        start(192'd3, 192'd5);
        wait_done("post_rst", 384'd15);
        take();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
